// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared state encoding and one-hot helpers for the ring arbiter
package ring_arb_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int MAXW = 64;
  function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] v, input int n);
    return ((v << 1) | (v >> (n - 1))) & ~({MAXW{1'b1}} << n);
  endfunction
  function automatic int onehot_to_idx(input logic [MAXW-1:0] v);
    int idx = 0;
    for (int i = 0; i < MAXW; i++) if (v[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/ring_rr_pick.sv
// ring_rr_pick: first set request scanning circularly upward from the one-hot pointer
module ring_rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner
);
  logic [2*N-1:0] dbl, iso;
  always_comb begin
    dbl = {req, req & ~(ptr - N'(1))};
    iso = dbl & (~dbl + (2*N)'(1));
    winner = iso[N-1:0] | iso[2*N-1:N];
  end
endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with one-hot priority ring and capped tenure
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(N),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] owner_idx,
  output logic [BW-1:0] burst_cnt
);
  logic state, rel;
  logic [N-1:0] ptr, ptr_nxt, win;
  always_comb begin
    rel = state == ST_GRANT && (~|(req & gnt) || burst_cnt == BW'(MAX_BURST));
    ptr_nxt = rel ? N'(rotl1(MAXW'(gnt), N)) : ptr;
  end
  ring_rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr_nxt), .winner(win));
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= ST_IDLE;
      ptr <= N'(1);
      gnt <= '0;
      gnt_valid <= 1'b0;
      owner_idx <= '0;
      burst_cnt <= '0;
    end else if (state == ST_IDLE || rel) begin
      ptr <= ptr_nxt;
      state <= |req ? ST_GRANT : ST_IDLE;
      gnt <= win;
      gnt_valid <= |req;
      owner_idx <= IW'(onehot_to_idx(MAXW'(win)));
      burst_cnt <= |req ? BW'(1) : '0;
    end else begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_ring_rr_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [7:0] req = '0, gnt;
  logic gnt_valid;
  logic [2:0] owner_idx, burst_cnt;
  int n_chk = 0, n_fail = 0;
  int m_own = -1, m_cnt = 0, m_ptr = 0;

  ring_rr_arbiter #(.N(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .owner_idx(owner_idx), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [14:0] mexp();
    logic [7:0] g = (m_own < 0) ? 8'h00 : 8'(1 << m_own);
    logic [2:0] ix = (m_own < 0) ? 3'd0 : 3'(m_own);
    return {g, m_own >= 0, ix, 3'(m_cnt)};
  endfunction

  task automatic model_edge(input logic r_n, input logic fl, input logic [7:0] rq);
    if (!r_n || fl) begin
      m_own = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_own < 0) begin
      if (rq != 0) begin m_own = pick(rq, m_ptr); m_cnt = 1; end
    end else if (!rq[m_own] || m_cnt == 4) begin
      m_ptr = (m_own + 1) % 8;
      if (rq != 0) begin m_own = pick(rq, m_ptr); m_cnt = 1; end
      else begin m_own = -1; m_cnt = 0; end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input logic r_n, input logic fl, input logic [7:0] rq);
    rst_n = r_n; flush = fl; req = rq;
    @(posedge clk);
    model_edge(r_n, fl, rq);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 8'hFF);
      n_chk++;
      if ({gnt, gnt_valid, owner_idx, burst_cnt} !== 15'd0 || dut.ptr !== 8'h01) begin
        n_fail++;
        $display("FAIL reset: gnt=%h v=%b idx=%0d cnt=%0d ptr=%h, want all 0 ptr=01", gnt, gnt_valid, owner_idx, burst_cnt, dut.ptr);
      end
    end
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 36; i++) begin
      logic [7:0] e;
      e = 8'd1 << ((i / 4) % 8);
      cyc(1'b1, 1'b0, 8'hFF);
      n_chk++;
      if (gnt !== e || burst_cnt !== 3'((i % 4) + 1) || !gnt_valid) begin
        n_fail++;
        $display("FAIL rotation[%0d]: gnt=%h cnt=%0d v=%b, want gnt=%h cnt=%0d v=1", i, gnt, burst_cnt, gnt_valid, e, (i % 4) + 1);
      end
    end
  endtask

  task automatic test_sole_burst();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 8'h10);
      n_chk++;
      if (gnt !== 8'h10 || owner_idx !== 3'd4 || burst_cnt !== 3'((i % 4) + 1)) begin
        n_fail++;
        $display("FAIL sole_burst[%0d]: gnt=%h idx=%0d cnt=%0d, want 10/4/%0d", i, gnt, owner_idx, burst_cnt, (i % 4) + 1);
      end
      if (i >= 4 && i % 4 == 0) begin
        n_chk++;
        if (dut.ptr !== 8'h20) begin
          n_fail++;
          $display("FAIL sole_ptr[%0d]: ptr=%h, want 20", i, dut.ptr);
        end
      end
    end
  endtask

  task automatic test_early_drop_and_wrap();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h00);
    n_chk++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || dut.state !== 1'b0 || dut.ptr !== 8'h02) begin
      n_fail++;
      $display("FAIL early_drop: gnt=%h v=%b st=%b ptr=%h, want 00/0/0/02", gnt, gnt_valid, dut.state, dut.ptr);
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] e;
      e = (i / 4 == 1) ? 8'h01 : 8'h80;
      cyc(1'b1, 1'b0, 8'h81);
      n_chk++;
      if (gnt !== e || burst_cnt !== 3'((i % 4) + 1)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: gnt=%h cnt=%0d, want %h/%0d", i, gnt, burst_cnt, e, (i % 4) + 1);
      end
      if (i == 4) begin
        n_chk++;
        if (dut.ptr !== 8'h01) begin
          n_fail++;
          $display("FAIL wrap_ptr: ptr=%h, want 01", dut.ptr);
        end
      end
    end
  endtask

  task automatic test_flush();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h0C);
    cyc(1'b1, 1'b0, 8'h0C);
    n_chk++;
    if (gnt !== 8'h04 || burst_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_pre: gnt=%h cnt=%0d, want 04/2", gnt, burst_cnt);
    end
    cyc(1'b1, 1'b1, 8'h0C);
    n_chk++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || burst_cnt !== 3'd0 || dut.ptr !== 8'h01) begin
      n_fail++;
      $display("FAIL flush: gnt=%h v=%b cnt=%0d ptr=%h, want 00/0/0/01", gnt, gnt_valid, burst_cnt, dut.ptr);
    end
    cyc(1'b1, 1'b0, 8'h0C);
    n_chk++;
    if (gnt !== 8'h04 || owner_idx !== 3'd2 || burst_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_post: gnt=%h idx=%0d cnt=%0d, want 04/2/1", gnt, owner_idx, burst_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h20);
    n_chk++;
    if (gnt !== 8'h20 || burst_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid_pre: gnt=%h cnt=%0d, want 20/3", gnt, burst_cnt);
    end
    cyc(1'b0, 1'b0, 8'h20);
    n_chk++;
    if ({gnt, gnt_valid, owner_idx, burst_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt=%h v=%b idx=%0d cnt=%0d, want all 0", gnt, gnt_valid, owner_idx, burst_cnt);
    end
    cyc(1'b1, 1'b0, 8'h20);
    n_chk++;
    if (gnt !== 8'h20 || owner_idx !== 3'd5 || burst_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_mid_post: gnt=%h idx=%0d cnt=%0d, want 20/5/1", gnt, owner_idx, burst_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    cyc(1'b0, 1'b0, 8'h00);
    r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      else if ($urandom_range(5) == 0) r[$urandom_range(7)] = 1'b0;
      cyc($urandom_range(59) != 0, $urandom_range(39) == 0, r);
      n_chk++;
      if ({gnt, gnt_valid, owner_idx, burst_cnt} !== mexp()) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%h got gnt=%h v=%b idx=%0d cnt=%0d, want {gnt,v,idx,cnt}=%h", i, r, gnt, gnt_valid, owner_idx, burst_cnt, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sole_burst();
    test_early_drop_and_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters using a rotating one-hot priority ring. It issues one registered one-hot grant at a time and caps each tenure at MAX_BURST cycles. It sits between the requesting engines and the shared datapath and drives the select/enable of that datapath.

## Interface
- N, default 8: number of requesters; N ≥ 2.
- MAX_BURST, default 4: maximum consecutive grant cycles per tenure; MAX_BURST ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous abort: drop any grant and return the ring to bit 0.
- req  input  N  per-requester request, level-sensitive, sampled on clk.
- gnt  output  N  registered one-hot grant; all zeros when idle.
- gnt_valid  output  1  registered; equals |gnt.
- owner_idx  output  $clog2(N)  binary index of the gnt bit; 0 when idle.
- burst_cnt  output  $clog2(MAX_BURST+1)  grant cycles used in the current tenure, counting from 1; 0 when idle.

## Operation
- Internal state:
  - ptr (N-bit one-hot priority pointer).
  - FSM with two states, IDLE and GRANT.
- Pick function: winner = first set bit of req, scanning circularly upward from ptr's bit, inclusive.
- Reset: rst_n=0 at a clock edge sets:
  - state=IDLE, ptr=1, gnt=0, gnt_valid=0, owner_idx=0, burst_cnt=0.
  - rst_n has priority over every other input.
- flush=1 (with rst_n=1) produces the same result as reset at that edge. flush has priority over req.
- IDLE:
  - req=0: stay in IDLE.
  - req≠0: at the next edge, gnt←pick(req, ptr), burst_cnt←1, go to GRANT.
- GRANT, evaluated each edge. Release occurs when req[owner]=0 or burst_cnt==MAX_BURST.
  - No release: hold gnt, burst_cnt←burst_cnt+1.
  - Release:
    - ptr←gnt rotated left by 1, so bit N-1 wraps to bit 0.
    - If req≠0: gnt←pick(req, new ptr) and burst_cnt←1, back-to-back with no dead cycle.
    - If req=0: gnt←0, burst_cnt←0, go to IDLE.
  - The released owner has the lowest priority on re-pick. If it is the only requester, it is re-granted immediately.
- ptr changes only on release, reset or flush. It is never advanced in IDLE.
- owner_idx and gnt_valid are registered alongside gnt and are always consistent with it.
- Requests raised mid-tenure have no effect until the next release.

## Timing
- Grant latency: 1 cycle. req rises before edge k → gnt is valid after edge k.
- Release latency: 1 cycle. req[owner] falls before edge k → gnt changes at edge k.
- Maximum tenure: exactly MAX_BURST consecutive cycles of gnt high.
- Fairness: a continuously requesting line waits at most (N-1)·MAX_BURST cycles between tenures.
- Outputs change only on rising clk. There are no combinational input-to-output paths.

## Structure
- Shared package ring_arb_pkg holds:
  - State encoding localparams: ST_IDLE=0, ST_GRANT=1.
  - onehot_to_idx function.
  - rotl1 function.
- One combinational sub-module, ring_rr_pick, with inputs req and ptr and output winner (one-hot, zero if req=0).
  - Implementation: double-width request vector masked by the thermometer of ptr.
  - It is instantiated once, fed by the next-ptr mux so that back-to-back re-pick works.
- Top level contains the FSM, ptr, burst counter and output registers.

## Test plan
All scenarios use N=8, MAX_BURST=4.
1. Reset and rotation:
   - Stimulus: hold rst_n=0 for 2 edges with req=8'hFF, then release.
   - Required: gnt=0 and burst_cnt=0 during reset. After reset, the grant sequence is 01 for 4 cycles, then 02, 04 … 80, then 01 again. There are no gap cycles and burst_cnt runs 1,2,3,4 per tenure.
2. Sole requester burst expiry:
   - Stimulus: req=8'h10 held.
   - Required: gnt=10 continuously, owner_idx=4, burst_cnt cycling 1..4. ptr becomes 8'h20 after each expiry.
3. Early drop and circular priority:
   - Stimulus: req=8'h01. Drop it after 2 grant cycles, then apply req=8'h81.
   - Required: gnt=0 and gnt_valid=0 on the edge after the drop, and the FSM is IDLE with ptr=02. Next grant is 80 (bit 7 precedes bit 0 scanning from bit 1), followed by 01.
4. Wrap-around:
   - Stimulus: owner is 80 with req=8'h81 until the tenure expires.
   - Required: next grant is 01 (ptr wraps to 01), then 80.
5. Flush mid-tenure:
   - Stimulus: gnt=04, burst_cnt=2, req=8'h0C; pulse flush for 1 cycle.
   - Required: gnt=0 and ptr=01 after the edge. Next edge gives gnt=04, because bit 2 is the first set bit scanning from bit 0.
6. Reset mid-tenure:
   - Stimulus: gnt=20, burst_cnt=3; assert rst_n=0 for 1 edge with req=8'h20.
   - Required: all outputs are 0 after the reset edge. After rst_n returns high, gnt=20 after 1 edge with burst_cnt=1.
